// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem request FSM, 2-entry queue.
// Delivers {inst, pc} to decode and accepts branch/jump redirects.
module instr_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            pc_en,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target
);

  localparam logic [1:0] L_DEPTH = 2'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISC
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_addr;
  logic [31:0]     r_q_inst [2];
  logic [PC_W-1:0] r_q_pc   [2];
  logic            r_rd;
  logic [1:0]      r_cnt;

  logic            w_redir;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_cnt_pp;
  logic            w_wr;
  logic            w_issue;
  logic            w_reissue;

  assign w_redir  = jump | branch_taken;
  assign w_tgt    = (jump ? jump_target : branch_target)
                    & ~PC_W'(3);
  assign w_pc_inc = r_pc + PC_W'(4);
  assign w_valid  = (r_cnt != 2'd0);
  assign w_pop    = w_valid & inst_ready;
  assign w_push   = (r_state == S_WAIT) & imem_ack & ~w_redir;
  assign w_cnt_pp = r_cnt + 2'(w_push) - 2'(w_pop);
  assign w_wr     = r_rd ^ r_cnt[0];

  assign imem_req   = (r_state != S_IDLE);
  assign imem_addr  = r_addr;
  assign inst_valid = w_valid;
  assign inst       = w_valid ? r_q_inst[r_rd] : 32'h0;
  assign inst_pc    = w_valid ? r_q_pc[r_rd] : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus issue/reissue strobes
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_reissue   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pc_en && !w_redir && (r_cnt < L_DEPTH)) begin
          w_state_nxt = S_WAIT;
          w_issue     = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (!w_redir && pc_en && (w_cnt_pp < L_DEPTH))
            w_reissue = 1'b1;
          else
            w_state_nxt = S_IDLE;
        end else if (w_redir) begin
          w_state_nxt = S_DISC;
        end
      end
      S_DISC: begin
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC, request address and queue occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_addr <= '0;
      r_cnt  <= 2'd0;
      r_rd   <= 1'b0;
    end else begin
      if (w_redir)     r_pc <= w_tgt;
      else if (w_push) r_pc <= w_pc_inc;
      if (w_issue)        r_addr <= r_pc;
      else if (w_reissue) r_addr <= w_pc_inc;
      r_cnt <= w_redir ? 2'd0 : w_cnt_pp;
      if (w_pop) r_rd <= ~r_rd;
    end
  end

  // Queue storage; contents are masked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[w_wr] <= imem_rdata;
      r_q_pc[w_wr]   <= r_addr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic,
// scored against a stream-level model of the fetch queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        pc_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;

  logic        x_rst = 1'b0;
  logic        x_req;
  logic [31:0] x_addr;
  logic        x_ack;
  logic [31:0] x_rdata;
  logic        x_valid;
  logic [31:0] x_inst;
  logic [31:0] x_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  instr_fetch_unit #(
    .PC_W(32), .RESET_PC(32'h0), .DEPTH(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .pc_en(pc_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target)
  );

  assign x_ack   = x_req;
  assign x_rdata = mem(x_addr);

  instr_fetch_unit #(
    .PC_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)
  ) u_wrap (
    .clk(clk), .rst_n(x_rst),
    .imem_req(x_req), .imem_addr(x_addr),
    .imem_ack(x_ack), .imem_rdata(x_rdata),
    .inst_valid(x_valid), .inst_ready(1'b1),
    .inst(x_inst), .inst_pc(x_pc), .pc_en(1'b1),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_target(32'h0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // memory responder
  int lat      = 1;
  bit rand_lat = 1'b0;
  bit noise    = 1'b0;
  bit busy     = 1'b0;
  int wcnt     = 0;
  int lat_cur  = 1;

  always @(posedge clk) begin
    #1;
    if (imem_req) begin
      if (!busy) begin
        busy    = 1'b1;
        wcnt    = 0;
        lat_cur = rand_lat ? int'($urandom_range(1, 3)) : lat;
      end
      wcnt++;
      if (wcnt >= lat_cur) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        busy       = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      busy       = 1'b0;
      imem_ack   = noise && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
  end

  // scoreboard and monitor
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        sbq[$];
  logic [31:0] dlv[$];
  int          n_acc = 0;
  logic [31:0] f_pc  = 32'h0;
  bit          taint = 1'b0;

  bit          p_rst   = 1'b0;
  bit          p_req   = 1'b0;
  logic [31:0] p_addr  = 32'h0;
  bit          p_pc_en = 1'b0;
  bit          p_redir = 1'b0;
  int          p_cnt   = 0;
  bit          p_taint = 1'b0;
  bit          p_acc   = 1'b0;

  always @(negedge clk) begin
    bit exp_req;
    if (!p_rst) begin
      chk("req_after_reset", 32'(imem_req), 32'h0);
    end else if (!p_req || p_acc) begin
      if (!p_req)
        exp_req = p_pc_en && !p_redir && (p_cnt < 2);
      else
        exp_req = !p_taint && !p_redir && p_pc_en &&
                  (sbq.size() < 2);
      chk("req_issue", 32'(imem_req), 32'(exp_req));
      if (imem_req === 1'b1 && exp_req)
        chk("req_addr", imem_addr, f_pc);
    end else begin
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", imem_addr, p_addr);
    end
    chk("valid", 32'(inst_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk("head_inst", inst, sbq[0].inst);
      chk("head_pc", inst_pc, sbq[0].pc);
    end else begin
      chk("empty_inst", inst, 32'h0);
      chk("empty_pc", inst_pc, 32'h0);
    end
    p_rst   = rst_n;
    p_req   = imem_req;
    p_addr  = imem_addr;
    p_pc_en = pc_en;
    p_redir = jump | branch_taken;
    p_cnt   = sbq.size();
    p_taint = taint;
    p_acc   = imem_req & imem_ack;
    if (!rst_n) begin
      sbq.delete();
      f_pc  = 32'h0;
      taint = 1'b0;
    end else begin
      if (inst_valid && inst_ready && sbq.size() != 0) begin
        dlv.push_back(sbq[0].pc);
        sbq.delete(0);
      end
      if (p_acc) begin
        if (!taint && !p_redir) begin
          sbq.push_back('{mem(imem_addr), imem_addr});
          n_acc++;
          f_pc = f_pc + 32'd4;
        end
        taint = 1'b0;
      end
      if (p_redir) begin
        sbq.delete();
        f_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        if (imem_req && !p_acc) taint = 1'b1;
      end
    end
  end

  // wrap instance logger
  logic [31:0] xa[$];
  logic [31:0] xp[$];
  logic [31:0] xi[$];

  always @(negedge clk) begin
    if (x_rst) begin
      if (x_req && xa.size() < 2) xa.push_back(x_addr);
      if (x_valid && xp.size() < 2) begin
        xp.push_back(x_pc);
        xi.push_back(x_inst);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cyc();
    rst_n = 1'b1;
    dlv.delete();
    n_acc = 0;
  endtask

  task automatic wait_req(input string nm);
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (imem_req) break;
    end
    chk(nm, 32'(imem_req), 32'h1);
  endtask

  task automatic wait_dlv();
    for (int k = 0; k < 60 && dlv.size() == 0; k++) cyc();
  endtask

  function automatic logic [31:0] first_dlv();
    return (dlv.size() != 0) ? dlv[0] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bit          ok;
    logic [31:0] last;
    int          r;

    repeat (3) cyc();
    x_rst = 1'b1;

    // reset then streaming, 1-cycle ack
    pc_en      = 1'b1;
    inst_ready = 1'b1;
    lat        = 1;
    do_reset(2);
    @(negedge clk);
    chk("lat_pre_valid", 32'(inst_valid), 32'h0);
    @(negedge clk);
    chk("lat_req", 32'(imem_req), 32'h1);
    chk("lat_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(inst_valid), 32'h1);
    chk("lat_pc", inst_pc, 32'h0);
    repeat (20) cyc();
    ok = (dlv.size() >= 15);
    foreach (dlv[i]) if (dlv[i] !== 32'(4 * i)) ok = 1'b0;
    chk("stream_seq", 32'(ok), 32'h1);

    // backpressure
    inst_ready = 1'b0;
    do_reset(2);
    repeat (10) cyc();
    chk("bp_entries", 32'(n_acc), 32'd2);
    chk("bp_req", 32'(imem_req), 32'h0);
    chk("bp_valid", 32'(inst_valid), 32'h1);
    inst_ready = 1'b1;
    repeat (5) cyc();
    ok = (dlv.size() >= 3);
    if (ok) ok = (dlv[0] == 32'h0) && (dlv[1] == 32'h4) &&
                 (dlv[2] == 32'h8);
    chk("bp_order", 32'(ok), 32'h1);

    // redirect with a request in flight
    lat = 3;
    do_reset(2);
    wait_req("rd_first_req");
    cyc();
    chk("rd_req_pre", 32'(imem_req), 32'h1);
    chk("rd_addr_pre", imem_addr, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    dlv.delete();
    cyc();
    branch_taken = 1'b0;
    chk("rd_req_disc", 32'(imem_req), 32'h1);
    chk("rd_addr_disc", imem_addr, 32'h0);
    wait_req("rd_new_req");
    chk("rd_new_addr", imem_addr, 32'h100);
    wait_dlv();
    chk("rd_first_pc", first_dlv(), 32'h100);

    // jump and branch together on a full queue
    lat        = 1;
    inst_ready = 1'b0;
    do_reset(2);
    repeat (6) cyc();
    chk("jb_full_req", 32'(imem_req), 32'h0);
    jump          = 1'b1;
    jump_target   = 32'h200;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    inst_ready    = 1'b1;
    dlv.delete();
    cyc();
    jump         = 1'b0;
    branch_taken = 1'b0;
    chk("jb_flush_valid", 32'(inst_valid), 32'h0);
    chk("jb_pop_seen", first_dlv(), 32'h0);
    dlv.delete();
    wait_req("jb_req");
    chk("jb_addr", imem_addr, 32'h200);
    wait_dlv();
    chk("jb_first_pc", first_dlv(), 32'h200);

    // pc_en stall and resume
    lat = 2;
    do_reset(2);
    repeat (10) cyc();
    pc_en = 1'b0;
    repeat (8) cyc();
    chk("stall_req", 32'(imem_req), 32'h0);
    chk("stall_drained", 32'(inst_valid), 32'h0);
    chk("stall_had_dlv", 32'(dlv.size() != 0), 32'h1);
    last = (dlv.size() != 0) ? dlv[$] : 32'h0;
    dlv.delete();
    pc_en = 1'b1;
    wait_dlv();
    chk("stall_resume_pc", first_dlv(), last + 32'd4);

    // reset while waiting on memory
    lat = 3;
    do_reset(2);
    repeat (4) cyc();
    wait_req("mr_req");
    rst_n = 1'b0;
    cyc();
    chk("mr_req_low", 32'(imem_req), 32'h0);
    chk("mr_valid_low", 32'(inst_valid), 32'h0);
    rst_n = 1'b1;
    wait_req("mr_refetch");
    chk("mr_refetch_addr", imem_addr, 32'h0);

    // random traffic
    rand_lat = 1'b1;
    noise    = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      inst_ready    = ($urandom_range(0, 9) < 7);
      pc_en         = ($urandom_range(0, 9) < 8);
      r             = $urandom_range(0, 99);
      jump          = (r < 4);
      branch_taken  = (r >= 2) && (r < 8);
      jump_target   = rand_tgt();
      branch_target = rand_tgt();
      cyc();
    end
    jump         = 1'b0;
    branch_taken = 1'b0;
    rst_n        = 1'b1;
    repeat (10) cyc();

    // wrap instance
    chk("wrap_req_cnt", 32'(xa.size()), 32'd2);
    chk("wrap_pc_cnt", 32'(xp.size()), 32'd2);
    chk("wrap_addr0", (xa.size() > 0) ? xa[0] : 32'h1, 32'hFFFF_FFFC);
    chk("wrap_addr1", (xa.size() > 1) ? xa[1] : 32'h1, 32'h0);
    chk("wrap_pc0", (xp.size() > 0) ? xp[0] : 32'h1, 32'hFFFF_FFFC);
    chk("wrap_pc1", (xp.size() > 1) ? xp[1] : 32'h1, 32'h0);
    chk("wrap_inst1", (xi.size() > 1) ? xi[1] : 32'h1, mem(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
